// File: rtl/sys_array_input_skew_pkg.sv
// Shared types and helpers for the systolic array input skew feeder.
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } skew_state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ARRAY_L_DEF    = 2;

    // Cycles spent draining the diagonal after the last vector is accepted.
    function automatic int flush_cycles(input int array_l);
        return array_l - 1;
    endfunction

endpackage

// File: rtl/sys_array_input_skew_if.sv
// Valid/ready input stream carrying one unskewed lane vector per transfer.
interface sys_array_input_skew_if #(
    parameter int DATA_WIDTH = sys_array_pkg::DATA_WIDTH_DEF,
    parameter int ARRAY_L    = sys_array_pkg::ARRAY_L_DEF
);
    logic [0:ARRAY_L-1][DATA_WIDTH-1:0] in_data;
    logic                               in_valid;
    logic                               in_last;
    logic                               in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/sys_array_input_skew_delay_line.sv
// DEPTH-stage register chain with async reset and synchronous clear.
module skew_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/sys_array_input_skew.sv
// Diagonal-skew feeder: lane j of each accepted vector reaches the array j cycles after lane 0.
//   state | meaning
//   IDLE  | waiting for the first vector of a burst
//   RUN   | burst in progress, accepting vectors
//   FLUSH | last vector accepted, draining the diagonal
//   DONE  | last element on the final lane, done pulse
module sys_array_input_skew
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_L    = ARRAY_L_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear,
    sys_array_input_skew_if.slave              in_bus,
    output logic [0:ARRAY_L-1][DATA_WIDTH-1:0] input_module,
    output logic [0:ARRAY_L-1]                 lane_valid,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_W-1:0]                   burst_count
);
    localparam int FLUSH_CYCLES = flush_cycles(ARRAY_L);
    localparam int FC_W         = (ARRAY_L > 1) ? $clog2(ARRAY_L) : 1;

    skew_state_t     state, next_state;
    logic [FC_W-1:0] flush_cnt;
    logic            in_ready_int;
    logic            accept;

    assign accept          = in_bus.in_valid & in_ready_int;
    assign in_bus.in_ready = in_ready_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (!in_bus.in_last)        next_state = RUN;
                        else if (FLUSH_CYCLES == 0) next_state = DONE;
                        else                        next_state = FLUSH;
                    end
                end
                FLUSH:   if (flush_cnt == FC_W'(1)) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_int = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                in_ready_int = !clear;
                busy         = 1'b0;
            end
            RUN:     in_ready_int = !clear;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Terminal count at 1: the DONE transition lands on the edge that registers the final lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if (clear) begin
            flush_cnt <= '0;
        end else if (accept && in_bus.in_last) begin
            flush_cnt <= FC_W'(FLUSH_CYCLES);
        end else if (state == FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_count <= '0;
        end else if (accept) begin
            if (state == IDLE)          burst_count <= CNT_W'(1);
            else if (burst_count != '1) burst_count <= burst_count + CNT_W'(1);
        end
    end

    for (genvar j = 0; j < ARRAY_L; j++) begin : g_lane
        logic [DATA_WIDTH:0] lane_d;
        logic [DATA_WIDTH:0] lane_q;

        assign lane_d = accept ? {1'b1, in_bus.in_data[j]} : '0;

        skew_delay_line #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (j + 1)
        ) u_delay (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .d       (lane_d),
            .q       (lane_q)
        );

        assign input_module[j] = lane_q[DATA_WIDTH-1:0];
        assign lane_valid[j]   = lane_q[DATA_WIDTH];
    end
endmodule

// File: tb/tb_sys_array_input_skew.sv
// Directed bench for sys_array_input_skew with a 2-lane and a 4-lane instance.
module tb_sys_array_input_skew;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear2  = 1'b0;
    logic clear4  = 1'b0;

    always #5 clk = ~clk;

    sys_array_input_skew_if #(.DATA_WIDTH(8), .ARRAY_L(2)) bus2 ();
    sys_array_input_skew_if #(.DATA_WIDTH(8), .ARRAY_L(4)) bus4 ();

    logic [0:1][7:0] im2;
    logic [0:1]      lv2;
    logic            busy2, done2;
    logic [15:0]     bc2;
    logic [0:3][7:0] im4;
    logic [0:3]      lv4;
    logic            busy4, done4;
    logic [15:0]     bc4;

    sys_array_input_skew #(.DATA_WIDTH(8), .ARRAY_L(2), .CNT_W(16)) u_dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear2),
        .in_bus       (bus2),
        .input_module (im2),
        .lane_valid   (lv2),
        .busy         (busy2),
        .done         (done2),
        .burst_count  (bc2)
    );

    sys_array_input_skew #(.DATA_WIDTH(8), .ARRAY_L(4), .CNT_W(16)) u_dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear4),
        .in_bus       (bus4),
        .input_module (im4),
        .lane_valid   (lv4),
        .busy         (busy4),
        .done         (done4),
        .burst_count  (bc4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int exp_a0[6] = '{1, 3, 5, 7, 9, 0};
    int exp_a1[6] = '{0, 2, 4, 6, 8, 10};
    int bub0[4]   = '{1, 0, 3, 0};
    int bub1[4]   = '{0, 2, 0, 4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic l, input logic [7:0] a, input logic [7:0] b);
        bus2.in_valid = v;
        bus2.in_last  = l;
        bus2.in_data  = {a, b};
    endtask

    initial begin
        logic done_seen;
        drive2(1'b0, 1'b0, 8'd0, 8'd0);
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
        bus4.in_data  = '0;

        #12;
        chk("rst_im", 32'(im2), 0);
        chk("rst_lv", 32'(lv2), 0);
        chk("rst_rdy", 32'(bus2.in_ready), 1);
        chk("rst_done", 32'(done2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_bc", 32'(bc2), 0);
        chk("rst_rdy4", 32'(bus4.in_ready), 1);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_im_%0d", i), 32'(im2), 0);
            chk($sformatf("idle_lv_%0d", i), 32'(lv2), 0);
        end

        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive2(1'b1, i == 4, 8'(2*i + 1), 8'(2*i + 2));
            else       drive2(1'b0, 1'b0, 8'd0, 8'd0);
            tick();
            chk($sformatf("burst_l0_%0d", i), 32'(im2[0]), exp_a0[i]);
            chk($sformatf("burst_l1_%0d", i), 32'(im2[1]), exp_a1[i]);
            chk($sformatf("burst_v0_%0d", i), 32'(lv2[0]), 32'(i < 5));
            chk($sformatf("burst_v1_%0d", i), 32'(lv2[1]), 32'(i > 0));
            chk($sformatf("burst_done_%0d", i), 32'(done2), 32'(i == 5));
            chk($sformatf("burst_rdy_%0d", i), 32'(bus2.in_ready), 32'(i < 4));
        end
        chk("burst_bc", 32'(bc2), 5);
        tick();
        chk("burst_idle_rdy", 32'(bus2.in_ready), 1);
        chk("burst_idle_busy", 32'(busy2), 0);
        chk("burst_idle_done", 32'(done2), 0);
        chk("burst_bc_hold", 32'(bc2), 5);

        for (int k = 0; k < 4; k++) begin
            if (k == 0)      drive2(1'b1, 1'b0, 8'd1, 8'd2);
            else if (k == 2) drive2(1'b1, 1'b1, 8'd3, 8'd4);
            else             drive2(1'b0, 1'b1, 8'd0, 8'd0);
            tick();
            chk($sformatf("bub_l0_%0d", k), 32'(im2[0]), bub0[k]);
            chk($sformatf("bub_l1_%0d", k), 32'(im2[1]), bub1[k]);
            chk($sformatf("bub_v0_%0d", k), 32'(lv2[0]), 32'(k == 0 || k == 2));
            chk($sformatf("bub_v1_%0d", k), 32'(lv2[1]), 32'(k == 1 || k == 3));
            chk($sformatf("bub_done_%0d", k), 32'(done2), 32'(k == 3));
        end
        chk("bub_bc", 32'(bc2), 2);
        drive2(1'b0, 1'b0, 8'd0, 8'd0);
        tick();

        drive2(1'b1, 1'b0, 8'd11, 8'd12);
        tick();
        drive2(1'b1, 1'b1, 8'd13, 8'd14);
        tick();
        drive2(1'b1, 1'b0, 8'd21, 8'd22);
        chk("b2b_flush_rdy", 32'(bus2.in_ready), 0);
        tick();
        chk("b2b_done", 32'(done2), 1);
        chk("b2b_done_l1", 32'(im2[1]), 14);
        chk("b2b_done_rdy", 32'(bus2.in_ready), 0);
        tick();
        chk("b2b_idle_rdy", 32'(bus2.in_ready), 1);
        chk("b2b_idle_bc", 32'(bc2), 2);
        chk("b2b_no_accept", 32'(lv2[0]), 0);
        tick();
        chk("b2b_new_bc", 32'(bc2), 1);
        chk("b2b_new_l0", 32'(im2[0]), 21);
        chk("b2b_new_busy", 32'(busy2), 1);
        drive2(1'b1, 1'b1, 8'd23, 8'd24);
        tick();
        drive2(1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        tick();
        chk("b2b_end_busy", 32'(busy2), 0);

        drive2(1'b1, 1'b0, 8'd1, 8'd2);
        tick();
        drive2(1'b1, 1'b0, 8'd3, 8'd4);
        tick();
        drive2(1'b1, 1'b0, 8'd5, 8'd6);
        clear2 = 1'b1;
        #1;
        chk("clr_rdy", 32'(bus2.in_ready), 0);
        tick();
        clear2 = 1'b0;
        drive2(1'b0, 1'b0, 8'd0, 8'd0);
        chk("clr_im", 32'(im2), 0);
        chk("clr_lv", 32'(lv2), 0);
        chk("clr_busy", 32'(busy2), 0);
        chk("clr_done", 32'(done2), 0);
        chk("clr_bc", 32'(bc2), 2);
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done2) done_seen = 1'b1;
        end
        chk("clr_no_done", 32'(done_seen), 0);
        chk("clr_im_after", 32'(im2), 0);

        drive2(1'b1, 1'b0, 8'd7, 8'd8);
        tick();
        chk("arst_pre_l0", 32'(im2[0]), 7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_im", 32'(im2), 0);
        chk("arst_lv", 32'(lv2), 0);
        chk("arst_busy", 32'(busy2), 0);
        chk("arst_bc", 32'(bc2), 0);
        chk("arst_rdy", 32'(bus2.in_ready), 1);
        drive2(1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        bus4.in_valid = 1'b1;
        bus4.in_last  = 1'b1;
        bus4.in_data  = {8'd1, 8'd2, 8'd3, 8'd4};
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                bus4.in_valid = 1'b0;
                bus4.in_last  = 1'b0;
                bus4.in_data  = '0;
                chk("l4_bc", 32'(bc4), 1);
            end
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("l4_lane%0d_t%0d", j, k), 32'(im4[j]), (j == k) ? j + 1 : 0);
                chk($sformatf("l4_v%0d_t%0d", j, k), 32'(lv4[j]), 32'(j == k));
            end
            chk($sformatf("l4_done_t%0d", k), 32'(done4), 32'(k == 3));
        end
        tick();
        chk("l4_end_done", 32'(done4), 0);
        chk("l4_end_busy", 32'(busy4), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sys_array_input_skew.md
Name: sys_array_input_skew

Overview:
- Upstream feeder for the weight-stationary systolic array.
- Accepts one unskewed input vector per cycle (one element per array row lane L) on a valid/ready stream.
- Drives the array's `input_module` bus with diagonal skew: lane j is delayed j cycles relative to lane 0. Idle lanes are zero-filled.
- Tracks burst boundaries and pulses `done` when the last element of a burst has been presented to the array.

Parameters:
- DATA_WIDTH, 8, element width in bits
- ARRAY_L, 2, number of input lanes; must match the array's ARRAY_L; must be >= 1
- CNT_W, 16, width of the burst vector counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; flushes pipeline, returns to IDLE
- in_data  in  [0:ARRAY_L-1][DATA_WIDTH-1:0]  unskewed input vector, lane j = element j
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the final vector of a burst; sampled only on accept
- in_ready  out  1  block can accept in_data this cycle
- input_module  out  [0:ARRAY_L-1][DATA_WIDTH-1:0]  skewed data to the array
- lane_valid  out  [0:ARRAY_L-1]  lane j of input_module carries real data (not fill)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, end of burst
- burst_count  out  CNT_W  vectors accepted in the current or most recent burst

Behaviour:
- Reset (async, reset_n=0): all outputs are 0, except in_ready, which is 1. All delay registers are 0. State = IDLE.
- Accept = in_valid & in_ready.
- in_ready = !clear & (state == IDLE | state == RUN).
- Lane j datapath is a chain of j+1 registers.
  - Stage 0 loads in_data[j] on accept, else 0.
  - lane_valid[j] runs through an identical chain loaded with the accept bit.
  - Vector accepted at edge t appears on input_module[j] during cycle t+j (after edge t+j).
  - Lane 0 therefore has 1-cycle latency from accept.
- No back-pressure from the array: outputs advance every cycle. Gaps in in_valid produce zero/invalid bubbles on the corresponding diagonal.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on accept with in_last=0. burst_count <= 1.
  - IDLE -> FLUSH on accept with in_last=1 (single-vector burst). burst_count <= 1.
  - RUN stays in RUN on accept with in_last=0 or on no accept; burst_count increments on every accept.
  - RUN -> FLUSH on accept with in_last=1.
  - FLUSH: in_ready=0. A down-counter loaded with ARRAY_L-1 times the flush. FLUSH -> DONE when the final element of the last vector is registered on input_module[ARRAY_L-1].
  - DONE: done=1 for exactly one cycle, coincident with input_module[ARRAY_L-1] holding the last vector's final element and lane_valid[ARRAY_L-1]=1. DONE -> IDLE next cycle. in_ready=0 during DONE.
  - ARRAY_L=1: FLUSH is skipped. An accept with in_last goes to DONE directly, and done coincides with the lane 0 output.
- burst_count saturates at 2^CNT_W-1 and holds its value in IDLE until the next burst starts.
- clear (any state): next edge zeroes all delay chains and lane_valid, sets state to IDLE, and forces done=0. in_ready=0 while clear=1. clear beats a simultaneous accept; that vector is dropped. burst_count is held.
- reset_n deasserted mid-burst: immediate async clear of everything, identical to the power-on state.
- in_last without in_valid is ignored.

Decomposition:
- Shared package sys_array_pkg:
  - skew_state_t enum {IDLE, RUN, FLUSH, DONE}
  - typedef for lane vector [0:ARRAY_L-1][DATA_WIDTH-1:0]
  - localparam FLUSH_CYCLES = ARRAY_L-1
- Sub-module skew_delay_line (params WIDTH, DEPTH): DEPTH-stage register chain with async reset and synchronous clear. Instantiated per lane via generate, with DEPTH=j+1 and WIDTH=DATA_WIDTH+1 (data plus valid).

Test Plan:
- Reset then idle: with reset_n=0, expect input_module=0, lane_valid=0, in_ready=1, done=0. After release with in_valid=0 for 10 cycles, outputs stay 0.
- Burst, ARRAY_L=2: vectors (1,2),(3,4),(5,6),(7,8),(9,10) on consecutive cycles, last on the fifth.
  - Expected lane0 sequence: 1,3,5,7,9,0.
  - Expected lane1 sequence: 0,2,4,6,8,10.
  - done high with lane1=10. burst_count=5. in_ready=0 for 2 cycles after the last accept.
- Bubble: vectors (1,2), gap, (3,4) last. Expect lane0: 1,0,3. Expect lane1: 0,2,0,4, with lane_valid tracking. done with lane1=4.
- Back-to-back bursts: second burst offered during FLUSH. in_ready=0, so there is no accept until IDLE. The second burst's burst_count starts at 1.
- clear mid-burst, in the cycle after (3,4) is accepted: next cycle all outputs are 0, state is IDLE, and done never pulses. A simultaneous in_valid vector is not accepted.
- ARRAY_L=4, single vector (1,2,3,4) with in_last. Expect lane j=j+1 at cycle t+j, and done only at cycle t+3 with lane3=4.
